// File: rtl/mcu_hub.sv
// Byte-link hub: routes MCU frames to one of NCLIENTS byte clients by target ID,
// muxes client readback, and aggregates/acknowledges client interrupts (hub ID 0xFF).
module mcu_hub #(
    parameter int NCLIENTS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mcu_strobe,
    input  logic                    mcu_start,
    input  logic [7:0]              mcu_din,
    output logic [7:0]              mcu_dout,
    output logic                    mcu_irq,
    output logic [NCLIENTS-1:0]     cl_strobe,
    output logic                    cl_start,
    output logic [7:0]              cl_din,
    input  logic [8*NCLIENTS-1:0]   cl_dout,
    input  logic [NCLIENTS-1:0]     cl_irq,
    output logic [NCLIENTS-1:0]     cl_iack
);

    // Link semantics: a byte transfers on every cycle mcu_strobe is high; there is no
    // back-pressure. mcu_start qualifies the strobe as byte 0 of a new frame.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FWD,
        ST_HUBCMD,
        ST_HUBMASK,
        ST_DROP
    } state_t;

    state_t                state;
    logic [2:0]            sel;
    logic [2:0]            rr_ptr;
    logic [7:0]            hub_dout;
    logic [NCLIENTS-1:0]   irq_mask;
    logic [NCLIENTS-1:0]   pending;
    logic [NCLIENTS-1:0]   scan_bits;
    logic [3:0]            scan;
    logic                  grant_found;
    logic [2:0]            grant_idx;
    logic [2:0]            rr_next;

    assign pending = cl_irq & irq_mask;

    // Round-robin search: first pending client at or after rr_ptr, wrapping at NCLIENTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        scan        = 4'd0;
        scan_bits   = '0;
        for (int k = 0; k < NCLIENTS; k++) begin
            scan = 4'(rr_ptr) + 4'(k);
            if (scan >= 4'(NCLIENTS)) begin
                scan = scan - 4'(NCLIENTS);
            end
            scan_bits = pending >> scan;
            if (!grant_found && scan_bits[0]) begin
                grant_found = 1'b1;
                grant_idx   = scan[2:0];
            end
        end
    end

    assign rr_next = (grant_idx == 3'(NCLIENTS - 1)) ? 3'd0 : grant_idx + 3'd1;

    assign mcu_dout = (state == ST_CMD || state == ST_FWD)
                      ? 8'(cl_dout >> {sel, 3'b000})
                      : hub_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sel       <= 3'd0;
            rr_ptr    <= 3'd0;
            hub_dout  <= 8'h00;
            irq_mask  <= '1;
            cl_strobe <= '0;
            cl_start  <= 1'b0;
            cl_din    <= 8'h00;
            cl_iack   <= '0;
            mcu_irq   <= 1'b0;
        end else begin
            cl_strobe <= '0;
            cl_iack   <= '0;
            mcu_irq   <= |pending;
            if (mcu_strobe) begin
                if (mcu_start) begin
                    // A start byte always wins, even mid-frame; the ID is never forwarded.
                    hub_dout <= 8'h00;
                    if (mcu_din < 8'(NCLIENTS)) begin
                        sel   <= mcu_din[2:0];
                        state <= ST_CMD;
                    end else if (mcu_din == 8'hFF) begin
                        state <= ST_HUBCMD;
                    end else begin
                        state <= ST_DROP;
                    end
                end else begin
                    case (state)
                        ST_CMD: begin
                            cl_strobe <= NCLIENTS'(1) << sel;
                            cl_start  <= 1'b1;
                            cl_din    <= mcu_din;
                            state     <= ST_FWD;
                        end
                        ST_FWD: begin
                            cl_strobe <= NCLIENTS'(1) << sel;
                            cl_start  <= 1'b0;
                            cl_din    <= mcu_din;
                        end
                        ST_HUBCMD: begin
                            state <= ST_DROP;
                            case (mcu_din)
                                8'h00: hub_dout <= 8'(pending);
                                8'h01: begin
                                    if (grant_found) begin
                                        hub_dout <= {1'b1, 4'b0000, grant_idx};
                                        cl_iack  <= NCLIENTS'(1) << grant_idx;
                                        rr_ptr   <= rr_next;
                                    end else begin
                                        hub_dout <= 8'h00;
                                    end
                                end
                                8'h02: begin
                                    hub_dout <= 8'(irq_mask);
                                    state    <= ST_HUBMASK;
                                end
                                default: hub_dout <= 8'h00;
                            endcase
                        end
                        ST_HUBMASK: begin
                            irq_mask <= mcu_din[NCLIENTS-1:0];
                            state    <= ST_DROP;
                        end
                        default: hub_dout <= 8'h00;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_hub.sv
// Scoreboarded bench for mcu_hub: directed frames push expected client strobes/acks;
// a negedge monitor pops and compares whenever the hub emits them.
module tb_mcu_hub;

    localparam int N  = 4;
    localparam int FW = N + 9;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             mcu_strobe = 1'b0;
    logic             mcu_start = 1'b0;
    logic [7:0]       mcu_din = 8'h00;
    logic [7:0]       mcu_dout;
    logic             mcu_irq;
    logic [N-1:0]     cl_strobe;
    logic             cl_start;
    logic [7:0]       cl_din;
    logic [8*N-1:0]   cl_dout = 32'hA15C_B2C3;
    logic [N-1:0]     cl_irq = '0;
    logic [N-1:0]     cl_iack;

    logic [FW-1:0]    exp_q[$];
    logic [N-1:0]     iack_q[$];
    logic [FW-1:0]    fwd_exp;
    logic [N-1:0]     iack_exp;
    int               total = 0;
    int               bad = 0;

    mcu_hub #(.NCLIENTS(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mcu_strobe(mcu_strobe),
        .mcu_start(mcu_start),
        .mcu_din(mcu_din),
        .mcu_dout(mcu_dout),
        .mcu_irq(mcu_irq),
        .cl_strobe(cl_strobe),
        .cl_start(cl_start),
        .cl_din(cl_din),
        .cl_dout(cl_dout),
        .cl_irq(cl_irq),
        .cl_iack(cl_iack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every client strobe or ack the hub emits must match the head of its queue.
    always @(negedge clk) begin
        if (reset_n && cl_strobe != '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got strobe=0x%0h din=0x%0h expected none", cl_strobe, cl_din);
            end else begin
                fwd_exp = exp_q.pop_front();
                check("fwd", {cl_strobe, cl_start, cl_din}, 32'(fwd_exp));
            end
        end
        if (reset_n && cl_iack != '0) begin
            if (iack_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_iack: got 0x%0h expected none", cl_iack);
            end else begin
                iack_exp = iack_q.pop_front();
                check("iack", 32'(cl_iack), 32'(iack_exp));
            end
        end
    end

    // One MCU byte; afterwards everything expected from it must already have been seen.
    task automatic send_byte(input logic s, input logic [7:0] d);
        @(negedge clk);
        mcu_strobe = 1'b1;
        mcu_start  = s;
        mcu_din    = d;
        @(negedge clk);
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
        #1;
        check("latency", 32'(exp_q.size() + iack_q.size()), 32'd0);
    endtask

    task automatic fwd_byte(input logic [2:0] c, input logic st, input logic [7:0] d);
        logic [N-1:0] oh;
        oh = N'(1) << c;
        exp_q.push_back({oh, st, d});
        send_byte(1'b0, d);
    endtask

    task automatic hub_cmd(input string name, input logic [7:0] cmd, input logic [7:0] exp_dout,
                           input logic [N-1:0] exp_iack);
        send_byte(1'b1, 8'hFF);
        if (exp_iack != '0) iack_q.push_back(exp_iack);
        send_byte(1'b0, cmd);
        check(name, 32'(mcu_dout), 32'(exp_dout));
    endtask

    task automatic mask_write(input logic [7:0] old_mask, input logic [7:0] new_mask);
        hub_cmd("mask_readback", 8'h02, old_mask, '0);
        send_byte(1'b0, new_mask);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"}, 32'(cl_strobe), 32'd0);
        check({tag, "_start"}, 32'(cl_start), 32'd0);
        check({tag, "_din"}, 32'(cl_din), 32'd0);
        check({tag, "_iack"}, 32'(cl_iack), 32'd0);
        check({tag, "_irq"}, 32'(mcu_irq), 32'd0);
        check({tag, "_dout"}, 32'(mcu_dout), 32'd0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Route to client 1 (HID)
        send_byte(1'b1, 8'h01);
        check("cmd_readback", 32'(mcu_dout), 32'hB2);
        fwd_byte(3'd1, 1'b1, 8'h02);
        fwd_byte(3'd1, 1'b0, 8'h05);
        fwd_byte(3'd1, 1'b0, 8'hFB);

        // Readback mux on client 2, then a bad ID drops the rest
        send_byte(1'b1, 8'h02);
        fwd_byte(3'd2, 1'b1, 8'h11);
        fwd_byte(3'd2, 1'b0, 8'h22);
        check("fwd_readback", 32'(mcu_dout), 32'h5C);
        send_byte(1'b1, 8'h07);
        check("drop_dout", 32'(mcu_dout), 32'h00);
        send_byte(1'b0, 8'h33);
        check("drop_dout2", 32'(mcu_dout), 32'h00);

        // Start byte in CMD preempts: client 0 sees nothing, client 3 gets the frame
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h03);
        fwd_byte(3'd3, 1'b1, 8'h44);
        check("preempt_readback", 32'(mcu_dout), 32'hA1);

        // Interrupt status and round-robin acknowledge
        cl_irq = 4'b1010;
        repeat (2) @(negedge clk);
        check("irq_on", 32'(mcu_irq), 32'd1);
        hub_cmd("status", 8'h00, 8'h0A, '0);
        hub_cmd("ack1", 8'h01, 8'h81, 4'b0010);
        hub_cmd("ack3", 8'h01, 8'h83, 4'b1000);
        hub_cmd("ack1_again", 8'h01, 8'h81, 4'b0010);
        cl_irq = 4'b0001;
        hub_cmd("ack_wrap0", 8'h01, 8'h80, 4'b0001);
        cl_irq = 4'b0100;
        hub_cmd("ack2", 8'h01, 8'h82, 4'b0100);
        cl_irq = 4'b0010;
        hub_cmd("ack_from_last", 8'h01, 8'h81, 4'b0010);
        cl_irq = 4'b0000;
        hub_cmd("ack_none", 8'h01, 8'h00, '0);
        hub_cmd("bad_cmd", 8'h05, 8'h00, '0);

        // Masking
        cl_irq = 4'b0010;
        repeat (2) @(negedge clk);
        check("irq_pre_mask", 32'(mcu_irq), 32'd1);
        mask_write(8'h0F, 8'h04);
        check("irq_hold", 32'(mcu_irq), 32'd1);
        @(negedge clk);
        check("irq_masked", 32'(mcu_irq), 32'd0);
        hub_cmd("ack_masked", 8'h01, 8'h00, '0);
        hub_cmd("status_masked", 8'h00, 8'h00, '0);
        cl_irq = 4'b0100;
        repeat (2) @(negedge clk);
        check("irq_mask4", 32'(mcu_irq), 32'd1);
        mask_write(8'h04, 8'h00);
        @(negedge clk);
        check("irq_mask0", 32'(mcu_irq), 32'd0);
        mask_write(8'h00, 8'h0F);
        cl_irq = 4'b0001;
        repeat (2) @(negedge clk);
        check("irq_restore", 32'(mcu_irq), 32'd1);

        // Reset while a forwarded strobe is on the client bus
        send_byte(1'b1, 8'h00);
        @(negedge clk);
        mcu_strobe = 1'b1;
        mcu_din    = 8'hAA;
        @(posedge clk);
        #1;
        check("abort_pre_strobe", 32'(cl_strobe), 32'h1);
        reset_n    = 1'b0;
        mcu_strobe = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_byte(1'b0, 8'h55);
        check("post_abort_dout", 32'(mcu_dout), 32'h00);
        @(negedge clk);
        check("post_abort_irq", 32'(mcu_irq), 32'd1);

        repeat (3) @(negedge clk);
        check("queues_empty", 32'(exp_q.size() + iack_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcu_hub.md
Name: mcu_hub

Overview:
- Sits between the IO-MCU byte link (strobe/start/data, one byte per strobe) and up to NCLIENTS byte-protocol clients: HID, OSD, storage.
- Frame byte 0 carries a target ID. The hub forwards the remainder of the frame to that client, re-framed so the client sees its own start byte.
- The hub muxes the selected client's readback byte and aggregates client IRQs into one MCU IRQ.
- The hub has its own register target (ID 0xFF) for IRQ status, round-robin IRQ acknowledge and IRQ masking.

Parameters:
NCLIENTS, 4, number of client ports; legal range 1..8; client IDs are 0..NCLIENTS-1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mcu_strobe  in  1  one-cycle pulse per MCU byte
mcu_start  in  1  qualifies mcu_strobe; marks byte 0 of a frame
mcu_din  in  8  MCU byte
mcu_dout  out  8  readback byte to MCU
mcu_irq  out  1  aggregated interrupt to MCU
cl_strobe  out  NCLIENTS  per-client byte strobe (one-hot or zero)
cl_start  out  1  start qualifier, shared by all clients
cl_din  out  8  byte to clients, shared
cl_dout  in  8*NCLIENTS  client readback bytes; client i occupies bits [8i+7:8i]
cl_irq  in  NCLIENTS  client interrupt levels
cl_iack  out  NCLIENTS  one-cycle acknowledge pulse per client

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, sel=0, hub_dout=0x00, irq_mask=all ones, rr_ptr=0.
  - cl_strobe=0, cl_start=0, cl_din=0x00, cl_iack=0, mcu_irq=0.
  - Reset mid-frame aborts the frame; no strobe or iack is emitted after reset asserts.
- States: IDLE, CMD, FWD, HUBCMD, HUBMASK, DROP.
- Any mcu_strobe with mcu_start=1, in any state, starts a new frame. mcu_din is the target ID:
  - ID < NCLIENTS: sel<=ID, go to CMD.
  - ID == 0xFF: go to HUBCMD.
  - Any other ID: go to DROP.
  - The ID byte is never forwarded.
- CMD: the next strobe is forwarded with cl_start=1, then go to FWD.
- FWD: each strobe is forwarded with cl_start=0; stay in FWD until the next start byte.
- Forwarding: registered, latency 1 cycle.
  - cl_strobe[sel] pulses exactly one cycle, cl_din=mcu_din, cl_start as above.
  - Other cl_strobe bits stay 0.
- DROP, and strobes in IDLE with start=0: ignored. hub_dout<=0x00; no client strobe.
- HUBCMD (first byte after ID 0xFF), decoded on its strobe:
  - 0x00 STATUS: hub_dout <= pending zero-extended, where pending = cl_irq & irq_mask. Go to DROP.
  - 0x01 ACK: grant = first set bit of pending, searched from rr_ptr upward with wrap at NCLIENTS.
    - If found: hub_dout <= {1'b1, 4'b0, idx[2:0]}; cl_iack[idx] pulses 1 cycle (registered, latency 1); rr_ptr <= (idx+1) mod NCLIENTS.
    - If none: hub_dout <= 0x00, no iack, rr_ptr unchanged.
    - Go to DROP.
  - 0x02 MASK: hub_dout <= irq_mask, go to HUBMASK. The next strobe sets irq_mask <= mcu_din[NCLIENTS-1:0], then go to DROP.
  - Other commands: hub_dout <= 0x00, go to DROP.
- mcu_dout (combinational): in CMD/FWD it is cl_dout[sel]; in all other states it is hub_dout.
  - Clients update their readback on their own strobe; the MCU samples the byte on its next transfer.
- mcu_irq is registered: |(cl_irq & irq_mask), latency 1 cycle.
- Boundary cases:
  - Start byte arriving in CMD before the client command byte: the client sees nothing; the new frame wins.
  - cl_irq drops between STATUS and ACK: ACK grants the next pending client or returns 0x00.
  - ACK with rr_ptr=NCLIENTS-1 wraps the search to 0.
  - A mask write of 0 forces mcu_irq low within 1 cycle.

Test Plan:
- Route to HID: frame [start 0x01, 0x02, 0x05, 0xFB] with NCLIENTS=4.
  - cl_strobe=0b0010 three times, each 1 cycle after its mcu_strobe.
  - cl_start=1,0,0; cl_din=0x02,0x05,0xFB.
  - Every byte is sent with mcu_start=0 except the ID byte (start=1).
- Readback mux: during FWD to client 2, drive cl_dout[2]=0x5C.
  - mcu_dout=0x5C.
  - After a new frame [start 0x07], mcu_dout=0x00 and no cl_strobe fires.
- IRQ round robin: cl_irq=0b1010, rr_ptr=0.
  - STATUS returns 0x0A.
  - ACK returns 0x81 and iack[1] pulses.
  - Next ACK returns 0x83 with iack[3].
  - Next ACK (clients still high) returns 0x81 again, exercising the wrap.
- Mask: hub MASK frame writes 0x04 while cl_irq=0b0010.
  - Readback of the MASK command byte is 0x0F.
  - mcu_irq falls 1 cycle after the write.
  - ACK returns 0x00 with no iack.
- Abort: start a frame to client 0, then apply reset_n=0 between bytes.
  - All outputs reach their reset values immediately.
  - After release, an un-started byte produces no cl_strobe.
